// File: rtl/logic_reduce_unit.sv
// Streaming bitwise reducer: folds WIDTH-bit beats with AND/OR/XOR/NAND into one
// registered result per packet, with valid/ready handshakes on both sides.
module logic_reduce_unit #(
    parameter int WIDTH     = 32,
    parameter int MAX_BEATS = 16,
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic             out_ovf
);

    // Handshake: a transfer happens on a rising clk edge where valid & ready are both 1;
    // the sender holds data stable while valid is high and ready is low.
    typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT, S_DRAIN} state_e;

    localparam logic [1:0] OP_NAND = 2'b11;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               ovf_q, ovf_d;
    logic               drain_q, drain_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [CW-1:0]      out_count_q, out_count_d;
    logic               out_zero_q, out_zero_d;
    logic               out_ovf_q, out_ovf_d;

    logic               in_fire;
    logic               out_fire;
    logic [CW-1:0]      cnt_inc;
    logic               at_max;
    logic [WIDTH-1:0]   fold_v;
    logic               load_res;
    logic [WIDTH-1:0]   res_src;
    logic [1:0]         res_op;
    logic [CW-1:0]      res_cnt;
    logic               res_ovf;
    logic [WIDTH-1:0]   res_val;

    // NAND accumulates as AND; the inversion is applied only when the result is emitted.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [1:0]       o);
        case (o)
            2'b01:   fold = a | b;
            2'b10:   fold = a ^ b;
            default: fold = a & b;
        endcase
    endfunction

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;
    assign cnt_inc  = cnt_q + CW'(1);
    assign at_max   = (cnt_inc == CW'(MAX_BEATS));
    assign fold_v   = fold(acc_q, in_data, op_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_q        <= 2'b00;
            ovf_q       <= 1'b0;
            drain_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            ovf_q       <= ovf_d;
            drain_q     <= drain_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_fire) state_d = in_last ? S_OUT : S_ACC;
            S_ACC:   if (in_fire && (in_last || at_max)) state_d = S_OUT;
            S_OUT:   if (out_fire) state_d = drain_q ? S_DRAIN : S_IDLE;
            S_DRAIN: if (in_fire && in_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        ovf_d       = ovf_q;
        drain_d     = drain_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;
        out_ovf_d   = out_ovf_q;
        load_res    = 1'b0;
        res_src     = fold_v;
        res_op      = op_q;
        res_cnt     = cnt_inc;
        res_ovf     = 1'b0;
        res_val     = '0;
        case (state_q)
            S_IDLE: begin
                if (in_fire) begin
                    acc_d    = in_data;
                    cnt_d    = CW'(1);
                    op_d     = op;
                    ovf_d    = 1'b0;
                    load_res = in_last;
                    res_src  = in_data;
                    res_op   = op;
                    res_cnt  = CW'(1);
                end
            end
            S_ACC: begin
                if (in_fire) begin
                    acc_d = fold_v;
                    cnt_d = cnt_inc;
                    if (in_last) begin
                        ovf_d    = 1'b0;
                        load_res = 1'b1;
                    end else if (at_max) begin
                        ovf_d    = 1'b1;
                        drain_d  = 1'b1;
                        load_res = 1'b1;
                        res_ovf  = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (out_fire) out_valid_d = 1'b0;
            end
            S_DRAIN: begin
                if (in_fire && in_last) drain_d = 1'b0;
            end
            default: ;
        endcase
        if (load_res) begin
            res_val     = (res_op == OP_NAND) ? ~res_src : res_src;
            out_valid_d = 1'b1;
            out_data_d  = res_val;
            out_count_d = res_cnt;
            out_zero_d  = (res_val == '0);
            out_ovf_d   = res_ovf;
        end
    end

    // in_ready is forced low while reset is held so no beat is taken during reset.
    always_comb begin
        in_ready  = rst_n && (state_q != S_OUT);
        out_valid = out_valid_q;
        out_data  = out_data_q;
        out_count = out_count_q;
        out_zero  = out_zero_q;
        out_ovf   = out_ovf_q;
    end

endmodule

// File: tb/tb_logic_reduce_unit.sv
// Directed bench for logic_reduce_unit (WIDTH=8, MAX_BEATS=4) with a packet-level
// reference model, a per-cycle output checker and literal expectations.
module tb_logic_reduce_unit;

    localparam int W  = 8;
    localparam int MB = 4;
    localparam int CW = 3;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_NAND = 2'b11;

    typedef logic [W-1:0] beat_q_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic [1:0]    op = 2'b00;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic [CW-1:0] out_count;
    logic          out_zero;
    logic          out_ovf;

    int n_checks = 0;
    int n_pass = 0;
    int result_cnt = 0;

    logic [W+CW:0] exp_q[$];
    logic [W-1:0]  last_data = '0;
    logic [CW-1:0] last_cnt = '0;
    logic          last_zero = 1'b0;
    logic          last_ovf = 1'b0;
    logic          prev_hold = 1'b0;
    logic [W+CW+1:0] prev_pack = '0;

    always #5 clk = ~clk;

    logic_reduce_unit #(.WIDTH(W), .MAX_BEATS(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .op(op),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_zero(out_zero), .out_ovf(out_ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Reference: fold the first MB beats with the first beat's operator, invert for NAND.
    task automatic model_packet(input beat_q_t b, input logic [1:0] op0);
        int n = b.size();
        int k = (n > MB) ? MB : n;
        logic [W-1:0] r = b[0];
        for (int i = 1; i < k; i++) begin
            if (op0 == OP_OR)       r = r | b[i];
            else if (op0 == OP_XOR) r = r ^ b[i];
            else                    r = r & b[i];
        end
        if (op0 == OP_NAND) r = ~r;
        exp_q.push_back({(n > MB), CW'(k), r});
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic l, input logic [1:0] o);
        logic rdy;
        bit   done = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        op       = o;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) done = 1;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) check("beat_accept_timeout", 32'(done), 1);
    endtask

    task automatic send_packet(input beat_q_t b, input logic [1:0] op0, input logic [1:0] op_rest);
        model_packet(b, op0);
        for (int i = 0; i < b.size(); i++)
            send_beat(b[i], (i == b.size() - 1), (i == 0) ? op0 : op_rest);
        if (b.size() <= MB) check("latency_valid", 32'(out_valid), 1);
    endtask

    task automatic wait_result(input int target);
        for (int i = 0; i < 200 && result_cnt < target; i++) @(posedge clk);
        #1;
        check("result_arrived", 32'(result_cnt >= target), 1);
    endtask

    task automatic check_last(input logic [W-1:0] d, input logic [CW-1:0] c,
                              input logic z, input logic v);
        check("lit_data", 32'(last_data), 32'(d));
        check("lit_count", 32'(last_cnt), 32'(c));
        check("lit_zero", 32'(last_zero), 32'(z));
        check("lit_ovf", 32'(last_ovf), 32'(v));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_out_valid"}, 32'(out_valid), 0);
        check({tag, "_out_data"}, 32'(out_data), 0);
        check({tag, "_out_count"}, 32'(out_count), 0);
        check({tag, "_out_zero"}, 32'(out_zero), 0);
        check({tag, "_out_ovf"}, 32'(out_ovf), 0);
    endtask

    // Scoreboard: checks holding, flag consistency and each result at its handshake.
    always @(negedge clk) begin
        logic [W+CW:0] e;
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", 32'(out_valid), 1);
                check("hold_outputs", 32'({out_zero, out_ovf, out_count, out_data}), 32'(prev_pack));
            end
            if (out_valid) begin
                check("in_ready_low_in_out", 32'(in_ready), 0);
                check("zero_flag", 32'(out_zero), 32'(out_data == '0));
                if (out_ready) begin
                    check("result_expected", 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("result", 32'({out_ovf, out_count, out_data}), 32'(e));
                    end
                    last_data = out_data;
                    last_cnt  = out_count;
                    last_zero = out_zero;
                    last_ovf  = out_ovf;
                    result_cnt++;
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_pack = {out_zero, out_ovf, out_count, out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        send_packet('{8'hF0, 8'h3C, 8'hFF}, OP_AND, OP_AND);
        wait_result(1);
        check_last(8'h30, 3'd3, 1'b0, 1'b0);

        out_ready = 1'b0;
        send_packet('{8'hAA, 8'h55}, OP_XOR, OP_XOR);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_valid", 32'(out_valid), 1);
            check("bp_data", 32'(out_data), 32'h FF);
            check("bp_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_hs_valid", 32'(out_valid), 0);
        check("post_hs_in_ready", 32'(in_ready), 1);
        check("post_hs_results", 32'(result_cnt), 2);
        check_last(8'hFF, 3'd1 + 3'd1, 1'b0, 1'b0);

        send_packet('{8'hFF}, OP_NAND, OP_NAND);
        wait_result(3);
        check_last(8'h00, 3'd1, 1'b1, 1'b0);
        send_packet('{8'h0F, 8'hF0}, OP_NAND, OP_NAND);
        wait_result(4);
        check_last(8'hFF, 3'd2, 1'b0, 1'b0);

        send_packet('{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20}, OP_OR, OP_OR);
        wait_result(5);
        check_last(8'h0F, 3'd4, 1'b0, 1'b1);
        send_packet('{8'h80}, OP_OR, OP_OR);
        wait_result(6);
        check_last(8'h80, 3'd1, 1'b0, 1'b0);

        send_packet('{8'hFF, 8'hFF, 8'hFF, 8'hFF}, OP_AND, OP_AND);
        wait_result(7);
        check_last(8'hFF, 3'd4, 1'b0, 1'b0);

        send_packet('{8'h0F, 8'hF0}, OP_AND, OP_OR);
        wait_result(8);
        check_last(8'h00, 3'd2, 1'b1, 1'b0);

        send_beat(8'h11, 1'b0, OP_AND);
        send_beat(8'h22, 1'b0, OP_AND);
        rst_n = 1'b0;
        #1;
        check_all_zero("midpkt_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send_beat(8'h3C, 1'b1, OP_OR);
        check("out_state_valid", 32'(out_valid), 1);
        check("out_state_data", 32'(out_data), 32'h3C);
        rst_n = 1'b0;
        #1;
        check_all_zero("out_reset");
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        send_packet('{8'h5A}, OP_OR, OP_OR);
        wait_result(9);
        check_last(8'h5A, 3'd1, 1'b0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("total_results", 32'(result_cnt), 9);
        check("exp_queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
